// File: rtl/wr_matcher.sv
// Dataflow operand matcher: pairs left/right worker results by {dest_addr, color}
// and emits match tokens. Define WR_MATCHER_STATS_EN to add the MATCH_COUNT port.

module wr_matcher_entry (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] key,
  input  logic        side,
  input  logic [31:0] data,
  input  logic        wr,
  input  logic        clr,
  output logic        vld,
  output logic        hit_opp,
  output logic        hit_same,
  output logic [31:0] held
);
  logic        e_side;
  logic [31:0] e_key;
  logic        hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld    <= 1'b0;
      e_side <= 1'b0;
      e_key  <= '0;
      held   <= '0;
    end else if (clr) begin
      vld <= 1'b0;
    end else if (wr) begin
      vld    <= 1'b1;
      e_side <= side;
      e_key  <= key;
      held   <= data;
    end
  end

  assign hit      = vld && (e_key == key);
  assign hit_opp  = hit && (e_side != side);
  assign hit_same = hit && (e_side == side);
endmodule

module wr_matcher #(
  parameter int ENTRIES             = 8,
  parameter int WORKER_RESULT_WIDTH = 67,
  parameter int MATCH_TOKEN_WIDTH   = 96
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           RECEIVE_WR_VALID,
  output logic                           RECEIVE_WR_READY,
  input  logic [WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
  output logic                           SEND_MT_VALID,
  input  logic                           SEND_MT_READY,
  output logic [MATCH_TOKEN_WIDTH-1:0]   SEND_MT_DATA,
  output logic                           ERROR,
  output logic [4:0]                     OCCUPANCY
`ifdef WR_MATCHER_STATS_EN
  ,
  output logic [31:0]                    MATCH_COUNT
`endif
);
  localparam logic [1:0] K_SINGLE = 2'b00;
  localparam logic [1:0] K_LEFT   = 2'b01;
  localparam logic [1:0] K_RIGHT  = 2'b10;
  localparam logic [1:0] K_DISC   = 2'b11;

  logic [1:0]  kind;
  logic [15:0] in_addr, in_color;
  logic [31:0] in_key, in_data;
  logic        in_side, is_op, unused_opt2;

  assign kind        = RECEIVE_WR_DATA[65:64];
  assign in_addr     = RECEIVE_WR_DATA[63:48];
  assign in_color    = RECEIVE_WR_DATA[47:32];
  assign in_data     = RECEIVE_WR_DATA[31:0];
  assign in_key      = {in_addr, in_color};
  assign in_side     = (kind == K_RIGHT);
  assign is_op       = (kind == K_LEFT) || (kind == K_RIGHT);
  assign unused_opt2 = RECEIVE_WR_DATA[WORKER_RESULT_WIDTH-1];

  logic [ENTRIES-1:0]       vld, hit_opp, hit_same, opp_oh, free_oh, wr, clr;
  logic [ENTRIES-1:0][31:0] held;
  logic                     any_opp, any_same, full, out_ok, xfer, new_tok;
  logic [31:0]              opp_data;
  logic [MATCH_TOKEN_WIDTH-1:0] tok;

  // Lowest set bit of the hit vector and lowest clear bit of the valid vector.
  assign opp_oh   = hit_opp & (~hit_opp + ENTRIES'(1));
  assign free_oh  = ~vld & (vld + ENTRIES'(1));
  assign any_opp  = |hit_opp;
  assign any_same = |hit_same;
  assign full     = &vld;
  assign out_ok   = !SEND_MT_VALID || SEND_MT_READY;

  // A completing operand frees an entry, so a full store must not block it.
  assign RECEIVE_WR_READY = !RST && ((kind == K_DISC) ||
                            (out_ok && ((kind == K_SINGLE) || any_opp || any_same || !full)));
  assign xfer    = RECEIVE_WR_VALID && RECEIVE_WR_READY;
  assign new_tok = xfer && ((kind == K_SINGLE) || (is_op && any_opp));

  genvar g;
  generate
    for (g = 0; g < ENTRIES; g++) begin : g_ent
      assign wr[g]  = xfer && is_op && !any_opp && (hit_same[g] || (!any_same && free_oh[g]));
      assign clr[g] = xfer && is_op && opp_oh[g];
      wr_matcher_entry u_ent (
        .CLK      (CLK),
        .RST      (RST),
        .key      (in_key),
        .side     (in_side),
        .data     (in_data),
        .wr       (wr[g]),
        .clr      (clr[g]),
        .vld      (vld[g]),
        .hit_opp  (hit_opp[g]),
        .hit_same (hit_same[g]),
        .held     (held[g])
      );
    end
  endgenerate

  always_comb begin
    opp_data  = '0;
    OCCUPANCY = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      opp_data  = opp_data | (held[i] & {32{opp_oh[i]}});
      OCCUPANCY = OCCUPANCY + 5'(vld[i]);
    end
  end

  // Left operand always lands in data_left regardless of arrival order.
  always_comb begin
    tok = {in_addr, in_color, in_data, 32'h0};
    if (is_op) begin
      if (kind == K_LEFT) tok = {in_addr, in_color, in_data, opp_data};
      else                tok = {in_addr, in_color, opp_data, in_data};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SEND_MT_VALID <= 1'b0;
      SEND_MT_DATA  <= '0;
      ERROR         <= 1'b0;
    end else begin
      if (new_tok) begin
        SEND_MT_VALID <= 1'b1;
        SEND_MT_DATA  <= tok;
      end else if (SEND_MT_READY) begin
        SEND_MT_VALID <= 1'b0;
      end
      if (xfer && is_op && !any_opp && any_same) ERROR <= 1'b1;
    end
  end

`ifdef WR_MATCHER_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST)                               MATCH_COUNT <= '0;
    else if (SEND_MT_VALID && SEND_MT_READY) MATCH_COUNT <= MATCH_COUNT + 32'd1;
  end
`endif
endmodule

// File: doc/wr_matcher.md
WR_MATCHER -- requirements
Module: wr_matcher

Interface
REQ-001 Parameter ENTRIES, default 8: number of matching-store entries, 2..16.
REQ-002 Parameter WORKER_RESULT_WIDTH, default 67: worker-result width, laid out {dest_option[2:0], dest_addr[15:0], color[15:0], data[31:0]}.
REQ-003 Parameter MATCH_TOKEN_WIDTH, default 96: token width, laid out {dest_addr[15:0], color[15:0], data_left[31:0], data_right[31:0]}.
REQ-004 CLK  input  1  single clock; all state changes on the rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 RECEIVE_WR_VALID  input  1  worker result offered.
REQ-007 RECEIVE_WR_READY  output  1  matcher accepts the offered result.
REQ-008 RECEIVE_WR_DATA  input  WORKER_RESULT_WIDTH  worker result.
REQ-009 SEND_MT_VALID  output  1  match token offered.
REQ-010 SEND_MT_READY  input  1  consumer accepts the token.
REQ-011 SEND_MT_DATA  output  MATCH_TOKEN_WIDTH  match token.
REQ-012 ERROR  output  1  sticky duplicate-operand flag.
REQ-013 OCCUPANCY  output  5  number of valid store entries.

Function
REQ-014 A transfer occurs on a rising edge where VALID and READY are both high; DATA is sampled only on that edge.
REQ-015 Kind is set by dest_option[1:0]: 00 single-input, 01 left operand, 10 right operand, 11 discard; dest_option[2] is ignored.
REQ-016 The store is fully associative, one entry = {valid, side, dest_addr, color, data}, key = {dest_addr, color}.
REQ-017 Single-input result: token {dest_addr, color, data, 32'h0} is registered, with SEND_MT_VALID high the next cycle.
REQ-018 Left/right result whose key hits an entry of the opposite side: the entry is freed and the token is registered next cycle, with data_left always the left operand and data_right always the right, regardless of arrival order.
REQ-019 Left/right result with no key hit: the result is written into the lowest-index free entry; no token.
REQ-020 Left/right result whose key hits an entry of the same side: the entry data is overwritten, ERROR is set, no token.
REQ-021 Discard result: accepted and dropped; no state change except the handshake.
REQ-022 The output register holds one token; SEND_MT_DATA is stable while SEND_MT_VALID is high and SEND_MT_READY is low.
REQ-023 RECEIVE_WR_READY = !RST && (discard || ((out_empty || SEND_MT_READY) && (kind is single-input, or a hit, or the store is not full))).
REQ-024 READY may depend combinationally on RECEIVE_WR_DATA; a full store never blocks a completing operand.
REQ-025 Same-cycle output drain and new token: the new token replaces the drained one, giving one token per cycle sustained.
REQ-026 Same-cycle free (match) and allocate are impossible, since there is one result per cycle; OCCUPANCY changes by at most ±1 per cycle.
REQ-027 Tokens leave in acceptance order.

Reset
REQ-028 While RST is high: RECEIVE_WR_READY=0, SEND_MT_VALID=0, SEND_MT_DATA=0, ERROR=0, OCCUPANCY=0, all entries invalid.
REQ-029 RST asserted mid-operation discards any pending token and all stored operands at the next edge.
REQ-030 A handshake coinciding with RST high is not a transfer.

Configuration
REQ-031 Macro WR_MATCHER_STATS_EN.
REQ-032 With WR_MATCHER_STATS_EN defined: output MATCH_COUNT [31:0] counts tokens transferred on SEND_MT, wraps from 32'hFFFF_FFFF to 0, and resets to 0.
REQ-033 Without WR_MATCHER_STATS_EN: the port and the counter are absent, and all other behaviour is identical.

Verification
REQ-034 Single-input: dest_option=3'b000, addr=16'h0f0f, color=16'habcd, data=32'h1234_abcd, SEND_MT_READY=1 -> next cycle SEND_MT_VALID=1, token {0f0f, abcd, 1234_abcd, 0}.
REQ-035 Right then left: 3'b010/16'hdead/16'h0f0f/32'h4321_5678, then 3'b001, same key, 32'hdead_beef -> one token {dead, 0f0f, dead_beef, 4321_5678}; OCCUPANCY goes 1 then 0.
REQ-036 Color isolation: left operands at addr 16'h00ff with colors 16'heeee and 16'h1111, then a right operand with color 16'h1111 -> the token carries the 16'h1111 left data; OCCUPANCY=1 after.
REQ-037 Full and backpressure: ENTRIES unmatched lefts -> READY=0 for a new unmatched left; READY=1 for the matching right. With SEND_MT_READY=0, a token is held stable and READY=0 for non-discard results.
REQ-038 Duplicate and reset: two left operands with the same key -> ERROR=1 and the second data is kept. RST for 1 cycle -> ERROR=0, OCCUPANCY=0, and the following right operand produces no token.
